// File: rtl/ttl_axi_master.sv
// AXI4 single-beat initiator for the TTL controller slave: turns simple write/read commands
// into 128-bit AXI4 transactions and returns status and readback on a valid/ready channel.
module ttl_axi_master #(
  parameter int unsigned AXI_ADDR_WIDTH   = 6,
  parameter int unsigned AXI_DATA_WIDTH   = 128,
  parameter int unsigned AXI_STROBE_WIDTH = AXI_DATA_WIDTH >> 3,
  parameter logic [15:0] AXI_ID           = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_aresetn,
  // Command channel
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [31:0]                   cmd_wdata,
  // Response channel
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [1:0]                    rsp_resp,
  output logic [31:0]                   rsp_rdata,
  // AW channel
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [15:0]                   m_axi_awid,
  output logic [1:0]                    m_axi_awburst,
  output logic [2:0]                    m_axi_awsize,
  output logic [7:0]                    m_axi_awlen,
  output logic [15:0]                   m_axi_awuser,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  // W channel
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_STROBE_WIDTH-1:0]   m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  // B channel
  input  logic [15:0]                   m_axi_bid,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  // AR channel
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [15:0]                   m_axi_arid,
  output logic [1:0]                    m_axi_arburst,
  output logic [2:0]                    m_axi_arsize,
  output logic [7:0]                    m_axi_arlen,
  output logic [15:0]                   m_axi_aruser,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  // R channel
  input  logic [15:0]                   m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  // Status
  output logic                          busy,
  output logic                          err_timeout,
  output logic                          err_proto
);

  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWrResp,
    StRdAddr,
    StRdData,
    StRsp
  } state_e;

  state_e state_q, state_d;

  logic                      cmd_ready_q, cmd_ready_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      bready_q, bready_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;
  logic [31:0]               rsp_rdata_q, rsp_rdata_d;
  logic [15:0]               wait_cnt_q, wait_cnt_d;
  logic                      err_timeout_q, err_timeout_d;
  logic                      err_proto_q, err_proto_d;

  logic cmd_hs, rsp_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic waiting;

  assign cmd_hs = cmd_valid & cmd_ready_q;
  assign rsp_hs = rsp_valid_q & rsp_ready;
  assign aw_hs  = awvalid_q & m_axi_awready;
  assign w_hs   = wvalid_q & m_axi_wready;
  assign b_hs   = bready_q & m_axi_bvalid;
  assign ar_hs  = arvalid_q & m_axi_arready;
  assign r_hs   = rready_q & m_axi_rvalid;

  // Only the AXI-facing states are bounded; a stalled response consumer is not an AXI fault.
  assign waiting = (state_q == StWr) || (state_q == StWrResp) ||
                   (state_q == StRdAddr) || (state_q == StRdData);

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_rdata_d   = rsp_rdata_q;
    wait_cnt_d    = wait_cnt_q;
    err_timeout_d = err_timeout_q;
    err_proto_d   = err_proto_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_hs) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          if (cmd_write) begin
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = StWr;
          end else begin
            arvalid_d = 1'b1;
            state_d   = StRdAddr;
          end
        end else begin
          // Also raises cmd_ready on the first cycle after reset release.
          cmd_ready_d = 1'b1;
        end
      end
      StWr: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = StWrResp;
        end
      end
      StWrResp: begin
        if (b_hs) begin
          bready_d    = 1'b0;
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = StRsp;
          if (m_axi_bid != AXI_ID) begin
            err_proto_d = 1'b1;
          end
        end
      end
      StRdAddr: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdData;
        end
      end
      StRdData: begin
        if (r_hs) begin
          rready_d    = 1'b0;
          rsp_resp_d  = m_axi_rresp;
          rsp_rdata_d = m_axi_rdata[31:0];
          rsp_valid_d = 1'b1;
          state_d     = StRsp;
          if ((m_axi_rid != AXI_ID) || !m_axi_rlast) begin
            err_proto_d = 1'b1;
          end
        end
      end
      StRsp: begin
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Saturating wait counter; restarts on every state change and every AXI handshake.
    if ((state_d != state_q) || aw_hs || w_hs || b_hs || ar_hs || r_hs) begin
      wait_cnt_d = '0;
    end else if (waiting && (wait_cnt_q != TimeoutLimit)) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end
    if (waiting && (wait_cnt_q == TimeoutLimit)) begin
      err_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q       <= StIdle;
      cmd_ready_q   <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_resp_q    <= '0;
      rsp_rdata_q   <= '0;
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
      err_proto_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_rdata_q   <= rsp_rdata_d;
      wait_cnt_q    <= wait_cnt_d;
      err_timeout_q <= err_timeout_d;
      err_proto_q   <= err_proto_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_rdata     = rsp_rdata_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awid    = AXI_ID;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awsize  = 3'b100;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awuser  = 16'd0;
  assign m_axi_awvalid = awvalid_q;

  assign m_axi_wdata   = {{(AXI_DATA_WIDTH-32){1'b0}}, wdata_q};
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = wvalid_q;
  assign m_axi_wvalid  = wvalid_q;

  assign m_axi_bready  = bready_q;

  assign m_axi_araddr  = addr_q;
  assign m_axi_arid    = AXI_ID;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arsize  = 3'b100;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_aruser  = 16'd0;
  assign m_axi_arvalid = arvalid_q;

  assign m_axi_rready  = rready_q;

  assign busy          = (state_q != StIdle);
  assign err_timeout   = err_timeout_q;
  assign err_proto     = err_proto_q;

  // Only the low 32 bits of read data carry the TTL pattern.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^m_axi_rdata[AXI_DATA_WIDTH-1:32];

endmodule

// File: tb/tb_ttl_axi_master.sv
// Bench for ttl_axi_master: a procedural AXI4 slave with programmable delays, a vector table,
// randomized transactions against a word-memory reference model, and hand-written corner cases.
`timescale 1ns/1ps
module tb_ttl_axi_master;

  localparam int          AW     = 6;
  localparam int          DW     = 128;
  localparam int          SW     = 16;
  localparam logic [15:0] ID     = 16'h0000;
  localparam int          Budget = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [1:0]    rsp_resp;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [15:0]   m_axi_awid, m_axi_awuser, m_axi_arid, m_axi_aruser;
  logic [1:0]    m_axi_awburst, m_axi_arburst;
  logic [2:0]    m_axi_awsize, m_axi_arsize;
  logic [7:0]    m_axi_awlen, m_axi_arlen;
  logic          m_axi_awvalid, m_axi_awready = 1'b0;
  logic [DW-1:0] m_axi_wdata;
  logic [SW-1:0] m_axi_wstrb;
  logic          m_axi_wlast, m_axi_wvalid, m_axi_wready = 1'b0;
  logic [15:0]   m_axi_bid = '0;
  logic [1:0]    m_axi_bresp = '0;
  logic          m_axi_bvalid = 1'b0, m_axi_bready;
  logic          m_axi_arvalid, m_axi_arready = 1'b0;
  logic [15:0]   m_axi_rid = '0;
  logic [DW-1:0] m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = '0;
  logic          m_axi_rlast = 1'b0, m_axi_rvalid = 1'b0, m_axi_rready;
  logic          busy, err_timeout, err_proto;

  ttl_axi_master #(
    .AXI_ADDR_WIDTH  (AW),
    .AXI_DATA_WIDTH  (DW),
    .AXI_STROBE_WIDTH(SW),
    .AXI_ID          (ID),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid), .m_axi_awburst(m_axi_awburst),
    .m_axi_awsize(m_axi_awsize), .m_axi_awlen(m_axi_awlen), .m_axi_awuser(m_axi_awuser),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid), .m_axi_arburst(m_axi_arburst),
    .m_axi_arsize(m_axi_arsize), .m_axi_arlen(m_axi_arlen), .m_axi_aruser(m_axi_aruser),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .busy(busy), .err_timeout(err_timeout), .err_proto(err_proto)
  );

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    int            d_a;     // AW/AR ready delay
    int            d_w;     // W ready delay
    int            d_b;     // B/R valid delay
    logic [1:0]    sresp;   // response the slave returns
    int            hold;    // cycles rsp_ready is held low
    logic [1:0]    exp_resp;
    logic [31:0]   exp_rdata;
  } txn_t;

  int n_cmp = 0;
  int n_bad = 0;
  int b_hs_cnt = 0;
  int rsp_hs_cnt = 0;

  logic [31:0]   smem    [64];   // slave storage, filled only from observed bus traffic
  logic [31:0]   ref_mem [64];   // reference model, filled only from issued commands
  logic [AW-1:0] cap_awaddr, cap_araddr;
  logic [DW-1:0] cap_wdata;

  always @(posedge clk) begin
    if (m_axi_bvalid && m_axi_bready) b_hs_cnt <= b_hs_cnt + 1;
    if (rsp_valid && rsp_ready) rsp_hs_cnt <= rsp_hs_cnt + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no handshake within %0d cycles", name, Budget);
  endtask

  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [31:0] data);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
    while (!cmd_ready) begin
      if (++n > Budget) begin expire("cmd_wait"); cmd_valid = 1'b0; return; end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic slave_aw(input int dly);
    int n = 0;
    logic [AW-1:0] a0;
    while (!m_axi_awvalid) begin
      if (++n > Budget) begin expire("aw_wait"); return; end
      @(negedge clk);
    end
    a0 = m_axi_awaddr;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check("aw_stable", 128'({m_axi_awvalid, m_axi_awaddr}), 128'({1'b1, a0}));
    end
    m_axi_awready = 1'b1;
    cap_awaddr = m_axi_awaddr;
    check("aw_fixed", 128'({m_axi_awid, m_axi_awburst, m_axi_awsize, m_axi_awlen, m_axi_awuser}),
          128'({ID, 2'b01, 3'b100, 8'h00, 16'h0000}));
    @(negedge clk);
    m_axi_awready = 1'b0;
    check("aw_drop", 128'(m_axi_awvalid), 128'(0));
  endtask

  task automatic slave_w(input int dly);
    int n = 0;
    while (!m_axi_wvalid) begin
      if (++n > Budget) begin expire("w_wait"); return; end
      @(negedge clk);
    end
    for (int i = 0; i < dly; i++) @(negedge clk);
    m_axi_wready = 1'b1;
    cap_wdata = m_axi_wdata;
    check("w_fields", 128'({m_axi_wvalid, m_axi_wstrb, m_axi_wlast}), 128'({1'b1, 16'hFFFF, 1'b1}));
    @(negedge clk);
    m_axi_wready = 1'b0;
    check("w_drop", 128'(m_axi_wvalid), 128'(0));
  endtask

  task automatic slave_b(input int dly, input logic [1:0] resp, input logic [15:0] bid);
    int n = 0;
    logic hs;
    smem[cap_awaddr] = cap_wdata[31:0];
    for (int i = 0; i < dly; i++) @(negedge clk);
    m_axi_bvalid = 1'b1; m_axi_bresp = resp; m_axi_bid = bid;
    do begin
      hs = m_axi_bready;
      @(negedge clk);
      if (!hs && ++n > Budget) begin expire("b_wait"); hs = 1'b1; end
    end while (!hs);
    m_axi_bvalid = 1'b0;
  endtask

  task automatic slave_ar(input int dly);
    int n = 0;
    while (!m_axi_arvalid) begin
      if (++n > Budget) begin expire("ar_wait"); return; end
      @(negedge clk);
    end
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check("ar_stable", 128'(m_axi_arvalid), 128'(1));
    end
    m_axi_arready = 1'b1;
    cap_araddr = m_axi_araddr;
    check("ar_fixed", 128'({m_axi_arid, m_axi_arburst, m_axi_arsize, m_axi_arlen, m_axi_aruser}),
          128'({ID, 2'b01, 3'b100, 8'h00, 16'h0000}));
    @(negedge clk);
    m_axi_arready = 1'b0;
    check("ar_drop", 128'(m_axi_arvalid), 128'(0));
  endtask

  task automatic slave_r(input int dly, input logic [1:0] resp, input logic [15:0] rid,
                         input logic last);
    int n = 0;
    logic hs;
    for (int i = 0; i < dly; i++) begin
      check("rready_hold", 128'(m_axi_rready), 128'(1));
      @(negedge clk);
    end
    m_axi_rvalid = 1'b1; m_axi_rresp = resp; m_axi_rid = rid; m_axi_rlast = last;
    m_axi_rdata = {$urandom, $urandom, $urandom, smem[cap_araddr]};
    do begin
      hs = m_axi_rready;
      @(negedge clk);
      if (!hs && ++n > Budget) begin expire("r_wait"); hs = 1'b1; end
    end while (!hs);
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
  endtask

  task automatic collect_rsp(input int hold, output logic [1:0] resp, output logic [31:0] rdata);
    int n = 0;
    resp = '0; rdata = '0;
    while (!rsp_valid) begin
      if (++n > Budget) begin expire("rsp_wait"); return; end
      @(negedge clk);
    end
    resp = rsp_resp; rdata = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      // A stray command pulse during the hold window must be ignored.
      cmd_valid = (i == 3); cmd_write = 1'b1; cmd_addr = 6'h2A; cmd_wdata = 32'hBAD0BAD0;
      @(negedge clk);
      check("rsp_hold", 128'({rsp_valid, rsp_resp, rsp_rdata, cmd_ready}),
            128'({1'b1, resp, rdata, 1'b0}));
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_release", 128'({rsp_valid, busy, cmd_ready}), 128'(3'b001));
  endtask

  task automatic run_txn(input txn_t t, input logic [15:0] sid, input logic last,
                         output logic [1:0] resp, output logic [31:0] rdata);
    int b0, r0;
    b0 = b_hs_cnt; r0 = rsp_hs_cnt;
    send_cmd(t.write, t.addr, t.wdata);
    if (t.write) begin
      fork
        slave_aw(t.d_a);
        slave_w(t.d_w);
      join
      slave_b(t.d_b, t.sresp, sid);
      check("awaddr", 128'(cap_awaddr), 128'(t.addr));
      check("wdata", 128'(cap_wdata), {96'h0, t.wdata});
    end else begin
      slave_ar(t.d_a);
      slave_r(t.d_b, t.sresp, sid, last);
      check("araddr", 128'(cap_araddr), 128'(t.addr));
    end
    collect_rsp(t.hold, resp, rdata);
    check("rsp_count", 128'(rsp_hs_cnt - r0), 128'(1));
    check("b_count", 128'(b_hs_cnt - b0), t.write ? 128'(1) : 128'(0));
  endtask

  function automatic txn_t mk(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                              input int da, input int dw, input int db, input logic [1:0] sr,
                              input int hold, input logic [1:0] er, input logic [31:0] ed);
    txn_t t;
    t.write = wr; t.addr = a; t.wdata = d; t.d_a = da; t.d_w = dw; t.d_b = db;
    t.sresp = sr; t.hold = hold; t.exp_resp = er; t.exp_rdata = ed;
    return t;
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    txn_t       vec [9];
    txn_t       t;
    logic [1:0] resp;
    logic [31:0] rdata;

    vec[0] = mk(1'b1, 6'h00, 32'hA5A50F0F, 0, 0, 0, 2'b00, 0,  2'b00, 32'h0);
    vec[1] = mk(1'b1, 6'h10, 32'h12345678, 3, 0, 0, 2'b00, 0,  2'b00, 32'h0);
    vec[2] = mk(1'b0, 6'h10, 32'h0,        0, 0, 0, 2'b00, 0,  2'b00, 32'h12345678);
    vec[3] = mk(1'b0, 6'h00, 32'h0,        2, 0, 3, 2'b00, 10, 2'b00, 32'hA5A50F0F);
    vec[4] = mk(1'b1, 6'h00, 32'hDEADBEEF, 0, 4, 2, 2'b10, 0,  2'b10, 32'h0);
    vec[5] = mk(1'b0, 6'h00, 32'h0,        1, 0, 1, 2'b00, 0,  2'b00, 32'hDEADBEEF);
    vec[6] = mk(1'b0, 6'h3F, 32'h0,        0, 0, 0, 2'b11, 0,  2'b11, 32'h0);
    vec[7] = mk(1'b1, 6'h3F, 32'h00000001, 1, 1, 1, 2'b01, 2,  2'b01, 32'h0);
    vec[8] = mk(1'b0, 6'h3F, 32'h0,        0, 0, 0, 2'b00, 6,  2'b00, 32'h00000001);

    for (int i = 0; i < 64; i++) begin smem[i] = '0; ref_mem[i] = '0; end

    // Reset state
    #12;
    check("reset_valids", 128'({cmd_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                m_axi_arvalid, m_axi_rready, busy, err_timeout, err_proto}),
          128'(0));
    check("reset_data", 128'({rsp_resp, rsp_rdata, m_axi_awaddr, m_axi_araddr}), 128'(0));
    check("reset_wdata", 128'(m_axi_wdata), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      run_txn(vec[i], ID, 1'b1, resp, rdata);
      if (vec[i].write) ref_mem[vec[i].addr] = vec[i].wdata;
      check($sformatf("vec%0d_resp", i), 128'(resp), 128'(vec[i].exp_resp));
      check($sformatf("vec%0d_rdata", i), 128'(rdata), 128'(vec[i].exp_rdata));
    end

    // Randomized traffic against the reference memory
    for (int i = 0; i < 40; i++) begin
      t.write = 1'($urandom_range(0, 1));
      t.addr  = 6'($urandom_range(0, 63));
      t.wdata = $urandom;
      t.d_a   = int'($urandom_range(0, 5));
      t.d_w   = int'($urandom_range(0, 5));
      t.d_b   = int'($urandom_range(0, 5));
      t.sresp = 2'($urandom_range(0, 3));
      t.hold  = int'($urandom_range(0, 6));
      t.exp_resp  = t.sresp;
      t.exp_rdata = t.write ? 32'h0 : ref_mem[t.addr];
      if (t.write) ref_mem[t.addr] = t.wdata;
      run_txn(t, ID, 1'b1, resp, rdata);
      check($sformatf("rnd%0d_resp", i), 128'(resp), 128'(t.exp_resp));
      check($sformatf("rnd%0d_rdata", i), 128'(rdata), 128'(t.exp_rdata));
    end

    // Timeout: awready withheld past the 16-cycle limit, then granted late
    check("pre_timeout", 128'(err_timeout), 128'(0));
    send_cmd(1'b1, 6'h08, 32'hCAFE0001);
    fork
      slave_aw(25);
      slave_w(0);
      begin
        repeat (12) @(negedge clk);
        check("timeout_early", 128'(err_timeout), 128'(0));
        repeat (10) @(negedge clk);
        check("timeout_set", 128'({err_timeout, m_axi_awvalid}), 128'(2'b11));
      end
    join
    slave_b(0, 2'b00, ID);
    collect_rsp(0, resp, rdata);
    check("timeout_rsp", 128'({resp, rdata}), 128'(0));
    check("timeout_sticky", 128'(err_timeout), 128'(1));

    // Asynchronous reset in WR_RESP
    send_cmd(1'b1, 6'h05, 32'h0F0F0F0F);
    fork
      slave_aw(0);
      slave_w(0);
    join
    check("in_wr_resp", 128'({busy, m_axi_bready}), 128'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 128'({cmd_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                               m_axi_arvalid, m_axi_rready, busy, err_timeout, err_proto}),
          128'(0));
    check("async_reset_addr", 128'(m_axi_awaddr), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_ready", 128'({cmd_ready, busy}), 128'(2'b10));

    // Wrong BID: response still delivered, protocol error flagged
    check("pre_proto", 128'(err_proto), 128'(0));
    run_txn(mk(1'b1, 6'h09, 32'h55AA55AA, 0, 0, 0, 2'b00, 0, 2'b00, 32'h0), 16'h0001, 1'b1,
            resp, rdata);
    check("bid_rsp", 128'({resp, rdata}), 128'(0));
    check("bid_proto", 128'(err_proto), 128'(1));

    // Missing RLAST on the single read beat
    reset_dut();
    check("proto_cleared", 128'(err_proto), 128'(0));
    run_txn(mk(1'b0, 6'h09, 32'h0, 0, 0, 0, 2'b00, 0, 2'b00, 32'h55AA55AA), ID, 1'b0,
            resp, rdata);
    check("rlast_rdata", 128'(rdata), 128'(32'h55AA55AA));
    check("rlast_proto", 128'(err_proto), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ttl_axi_master.md
Name: ttl_axi_master

Overview:
- AXI4 full-protocol initiator that drives the TTL controller's AXI4 slave port in hardware, replacing processor/bench-driven register writes.
- Accepts simple write/read commands carrying a 32-bit TTL pattern.
- Issues single-beat 128-bit AXI4 transactions and returns the response status and readback data on a valid/ready response channel.
- Sits between sequencing logic (e.g. a timed pattern player) and the TTLController slave.

Parameters:
AXI_ADDR_WIDTH, 6, address width, matching the slave.
AXI_DATA_WIDTH, 128, data width; must be 128.
AXI_STROBE_WIDTH, AXI_DATA_WIDTH>>3, write strobe width.
AXI_ID, 16'h0000, constant value driven on awid/arid.
TIMEOUT_CYCLES, 1024, wait-cycle limit per channel before the sticky timeout flag sets.

Ports:
m_axi_aclk  in  1  single clock
m_axi_aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accept
cmd_write  in  1  1=write, 0=read
cmd_addr  in  AXI_ADDR_WIDTH  target byte address
cmd_wdata  in  32  TTL pattern, bit n -> ttl_out_n
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_resp  out  2  BRESP or RRESP
rsp_rdata  out  32  rdata[31:0]; 0 for writes
m_axi_awaddr/awid/awburst/awsize/awlen/awuser/awvalid  out  ADDR/16/2/3/8/16/1  AW channel
m_axi_awready  in  1
m_axi_wdata/wstrb/wlast/wvalid  out  DATA/STROBE/1/1  W channel
m_axi_wready  in  1
m_axi_bid/bresp/bvalid  in  16/2/1; m_axi_bready out 1
m_axi_araddr/arid/arburst/arsize/arlen/aruser/arvalid  out  ADDR/16/2/3/8/16/1  AR channel
m_axi_arready  in  1
m_axi_rid/rdata/rresp/rlast/rvalid  in  16/DATA/2/1/1; m_axi_rready out 1
busy  out  1  state != IDLE
err_timeout  out  1  sticky; cleared only by reset
err_proto  out  1  sticky; set on bid/rid != AXI_ID or rvalid without rlast

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE.
  - All valid/ready outputs 0; rsp_resp=0, rsp_rdata=0; busy=0.
  - err flags 0; all address and data output registers 0.
  - Reset mid-transaction drops all valids immediately; no completion is owed.
- Fixed fields:
  - awburst=arburst=2'b01, awlen=arlen=0, awsize=arsize=3'b100, aw/aruser=0, aw/arid=AXI_ID.
  - wstrb all ones, wlast=1 whenever wvalid=1, wdata={96'b0,cmd_wdata}.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register addr and data.
  - Write: next cycle awvalid=wvalid=1, go to WR.
  - Read: arvalid=1, go to RD_ADDR.
- WR:
  - AW and W handshakes are independent, tracked by aw_done/w_done.
  - Each valid drops the cycle after its own handshake; both may complete in the same cycle.
  - Once both are done, bready=1 and go to WR_RESP.
  - Valids never deassert before their handshake (AXI stability rule); payload is held constant.
- WR_RESP: on bvalid&bready, capture bresp, set rsp_rdata=0, bready=0, go to RSP.
- RD_ADDR: on arready, arvalid=0, rready=1, go to RD_DATA.
- RD_DATA: on rvalid&rready, capture rresp and rdata[31:0], rready=0, go to RSP.
- RSP:
  - rsp_valid=1 with stable data until rsp_ready.
  - Then IDLE; cmd_ready=1 from the following cycle.
- Throughput and latency:
  - No outstanding pipelining: one transaction at a time.
  - With a zero-wait slave: write cmd accept -> rsp_valid in 4 cycles; read cmd accept -> rsp_valid in 4 cycles.
- Timeout:
  - A 16-bit wait counter resets on entry to each waiting state and on every handshake.
  - When it reaches TIMEOUT_CYCLES, err_timeout=1.
  - The FSM keeps waiting; transactions are never abandoned.
- cmd_valid while busy is ignored (cmd_ready=0). rsp_ready held high in IDLE has no effect.

Test Plan:
1. Reset, then write cmd addr=0x00 data=0xA5A5_0F0F against the TTLController slave -> one AW (awaddr=0, awsize=3'b100) and one W (wdata[31:0]=0xA5A50F0F, wstrb=16'hFFFF, wlast=1); rsp_resp=2'b00; ttl_out_00..31_p equal 0xA5A50F0F after the output latency.
2. Slave model asserts wready 3 cycles before awready -> W completes first, wvalid drops, awvalid stays high until its handshake; a single bready handshake follows; rsp_valid asserted exactly once.
3. Read cmd addr=0x00 after writing 0x1234_5678 -> arlen=0, rready held until rvalid&rlast; rsp_rdata=0x12345678, rsp_resp=0.
4. Hold rsp_ready low 10 cycles -> rsp_valid, rsp_resp and rsp_rdata stable; cmd_ready=0 throughout; a cmd_valid pulse during this window is ignored.
5. Slave never asserts awready with TIMEOUT_CYCLES=16 -> err_timeout=1 after 16 cycles, awvalid still 1; a late awready completes the transaction normally.
6. Assert reset mid-WR_RESP, and separately return bid=0x0001 -> all valids 0 and busy=0 asynchronously on reset; for the bid case err_proto=1 and the response is still delivered.
